l2_dat_port_ctrl: RTL and testbench
===================================

// Module: l2_dat_port_ctrl
// PURPOSE
//  Front-end controller for the true-dual-port L2 line data BRAM; owns both BRAM ports.
//  Port 1 serves the L1 data cache (D side) and port 2 serves the L1 instruction cache (I side).
//  Same-line collisions where at least one side writes are undefined in the BRAM, so this block serialises them with round-robin priority.
//  It also tracks read latency and returns held read data with a one-cycle valid strobe.
// PARAMETERS
//  NUM_COL     16                     byte lanes per line
//  COL_WIDTH   8                      bits per lane
//  ADDR_WIDTH  8                      line index width (2**ADDR_WIDTH lines)
//  DATA_WIDTH  NUM_COL*COL_WIDTH      line width (128)
//  CNT_WIDTH   16                     collision counter width (L2_DAT_CTRL_STATS_EN only)
// PORTS
//  clk_i           in   1           clock; all state changes on the rising edge
//  rst_ni          in   1           synchronous active-low reset
//  d_req_i         in   1           D request; address and data are held stable until d_gnt_o
//  d_we_i          in   1           D write (1) / read (0)
//  d_be_i          in   NUM_COL     D byte enables (writes only)
//  d_addr_i        in   ADDR_WIDTH  D line index
//  d_wdata_i       in   DATA_WIDTH  D write line
//  d_gnt_o         out  1           D request accepted this cycle (combinational)
//  d_rvalid_o      out  1           D read data valid (one-cycle pulse)
//  d_rdata_o       out  DATA_WIDTH  D read line, held until the next D rvalid
//  i_*             --   --          I-side set identical to d_* (i_req_i ... i_rdata_o)
//  ram_we_p1_o     out  1           BRAM port 1 write enable
//  ram_be_p1_o     out  NUM_COL     BRAM port 1 byte enables
//  ram_addr_p1_o   out  ADDR_WIDTH  BRAM port 1 address
//  ram_data_p1_o   out  DATA_WIDTH  BRAM port 1 write data
//  ram_data_p1_i   in   DATA_WIDTH  BRAM port 1 read data (registered, read-first, 1-cycle latency)
//  ram_*_p2_*      --   --          port 2 set identical to the port 1 set
//  coll_cnt_o      out  CNT_WIDTH   serialised-collision count (L2_DAT_CTRL_STATS_EN only)
// BEHAVIOUR
//  - Port mapping is fixed: D to port 1, I to port 2. Addresses and data always pass straight through.
//  - ram_we_pX_o = req & we & gnt. Byte enables pass through.
//  - Collision: d_req_i & i_req_i & (d_addr_i==i_addr_i) & (d_we_i|i_we_i).
//  - Two reads to the same line are not a collision; both are granted.
//  - No collision: every requesting side gets gnt in the same cycle (zero-wait). rr_ptr is unchanged.
//  - Collision: only the side selected by rr_ptr is granted (0 = D, 1 = I).
//    rr_ptr <= loser, so the loser wins next cycle; worst-case wait is 1 cycle.
//  - Read pipeline: a granted read in cycle T sets rd_pend_X at the T edge.
//    In T+1, ram_data_pX_i is valid. At the T+1 edge it is captured into X_rdata_o and X_rvalid_o <= 1.
//    X_rvalid_o is high during T+2 only. Read latency from grant to rvalid is 2 cycles.
//    Back-to-back grants give back-to-back rvalids.
//  - Writes give no response beyond the grant. A write with be=0 is still a write for collision purposes.
//  - X_rdata_o changes only on an X rvalid edge; otherwise it holds its value.
//  - Reset (rst_ni=0 at an edge):
//    rr_ptr=0; rd_pend_*=0; *_rvalid_o=0; *_rdata_o=0; coll_cnt_o=0.
//    In-flight reads are discarded with no rvalid.
//    gnt is forced to 0 and ram_we to 0 while rst_ni=0.
//  - A requester that drops req before gnt is legal; nothing is issued and rr_ptr is unchanged.
// CONFIGURATION
//  - L2_DAT_CTRL_STATS_EN defined:
//    coll_cnt_o exists and increments by 1 on each collision cycle.
//    It saturates at all-ones; it does not wrap.
//  - L2_DAT_CTRL_STATS_EN undefined: port coll_cnt_o and its counter are absent. All other behaviour is identical.
// TESTING
//  - Reset mid-read:
//    D read line 0x10 granted, then rst_ni=0 on the next edge.
//    -> no d_rvalid_o; all outputs 0 after reset.
//  - Independent access:
//    D write line 0x05 (be=FFFF, data=0xA5..A5) and I read line 0x06 in the same cycle.
//    -> both gnt=1.
//    Then D read 0x05 -> d_rvalid_o 2 cycles after grant with d_rdata_o=0xA5..A5.
//  - Collision, first round:
//    From reset, D write 0x20 and I read 0x20 in the same cycle.
//    -> cycle 0: d_gnt_o=1, i_gnt_o=0.
//    -> cycle 1: i_gnt_o=1, and the I side returns the newly written data.
//    -> coll_cnt_o=1.
//  - Round-robin fairness:
//    D write 0x30 and I write 0x30 held continuously for 4 cycles.
//    -> grants alternate I, D, I, D.
//    -> coll_cnt_o increments each cycle.
//  - Same-line double read:
//    D read 0x40 and I read 0x40 in the same cycle.
//    -> both granted, both rvalid 2 cycles later with identical data; coll_cnt_o unchanged.
//  - Counter saturation:
//    With CNT_WIDTH=4 and 20 collisions -> coll_cnt_o=0xF.
//    With the macro undefined -> the port is absent and the bench compiles without it.

Source files
------------

// File: rtl/l2_dat_port_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// l2_dat_port_ctrl : dual-port L2 line-data BRAM front end (D -> port 1, I -> port 2),
// round-robin serialisation of same-line write collisions. Option: L2_DAT_CTRL_STATS_EN
// Revision 1.0
// ----------------------------------------------------------------------------
module l2_dat_port_ctrl #(
  parameter int NUM_COL    = 16,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = NUM_COL*COL_WIDTH
`ifdef L2_DAT_CTRL_STATS_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [NUM_COL-1:0]    d_be_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,

  input  logic                  i_req_i,
  input  logic                  i_we_i,
  input  logic [NUM_COL-1:0]    i_be_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  input  logic [DATA_WIDTH-1:0] i_wdata_i,
  output logic                  i_gnt_o,
  output logic                  i_rvalid_o,
  output logic [DATA_WIDTH-1:0] i_rdata_o,

  output logic                  ram_we_p1_o,
  output logic [NUM_COL-1:0]    ram_be_p1_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_p1_o,
  output logic [DATA_WIDTH-1:0] ram_data_p1_o,
  input  logic [DATA_WIDTH-1:0] ram_data_p1_i,

  output logic                  ram_we_p2_o,
  output logic [NUM_COL-1:0]    ram_be_p2_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_p2_o,
  output logic [DATA_WIDTH-1:0] ram_data_p2_o,
  input  logic [DATA_WIDTH-1:0] ram_data_p2_i
`ifdef L2_DAT_CTRL_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  coll_cnt_o
`endif
);

  logic                  coll;
  logic                  rr_q, rr_d;
  logic                  d_rd_pend_q, i_rd_pend_q;
  logic                  d_rvalid_q, i_rvalid_q;
  logic [DATA_WIDTH-1:0] d_rdata_q, i_rdata_q;

  // Two reads of the same line are safe in the BRAM; only a write makes it a collision.
  assign coll = d_req_i & i_req_i & (d_addr_i == i_addr_i) & (d_we_i | i_we_i);

  always_comb begin
    d_gnt_o = 1'b0;
    i_gnt_o = 1'b0;
    rr_d    = rr_q;
    if (rst_ni) begin
      if (coll) begin
        d_gnt_o = ~rr_q;
        i_gnt_o = rr_q;
        rr_d    = ~rr_q;
      end else begin
        d_gnt_o = d_req_i;
        i_gnt_o = i_req_i;
      end
    end
  end

  assign ram_we_p1_o   = d_req_i & d_we_i & d_gnt_o;
  assign ram_be_p1_o   = d_be_i;
  assign ram_addr_p1_o = d_addr_i;
  assign ram_data_p1_o = d_wdata_i;

  assign ram_we_p2_o   = i_req_i & i_we_i & i_gnt_o;
  assign ram_be_p2_o   = i_be_i;
  assign ram_addr_p2_o = i_addr_i;
  assign ram_data_p2_o = i_wdata_i;

  // BRAM read data is valid the cycle after the grant; capture it and pulse rvalid.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q        <= 1'b0;
      d_rd_pend_q <= 1'b0;
      i_rd_pend_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      i_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      i_rdata_q   <= '0;
    end else begin
      rr_q        <= rr_d;
      d_rd_pend_q <= d_gnt_o & ~d_we_i;
      i_rd_pend_q <= i_gnt_o & ~i_we_i;
      d_rvalid_q  <= d_rd_pend_q;
      i_rvalid_q  <= i_rd_pend_q;
      if (d_rd_pend_q) d_rdata_q <= ram_data_p1_i;
      if (i_rd_pend_q) i_rdata_q <= ram_data_p2_i;
    end
  end

  assign d_rvalid_o = d_rvalid_q;
  assign i_rvalid_o = i_rvalid_q;
  assign d_rdata_o  = d_rdata_q;
  assign i_rdata_o  = i_rdata_q;

`ifdef L2_DAT_CTRL_STATS_EN
  logic [CNT_WIDTH-1:0] coll_cnt_q, coll_cnt_d;

  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (coll && (coll_cnt_q != {CNT_WIDTH{1'b1}})) begin
      coll_cnt_d = coll_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      coll_cnt_q <= '0;
    end else begin
      coll_cnt_q <= coll_cnt_d;
    end
  end

  assign coll_cnt_o = coll_cnt_q;
`else
  // Statistics are not built; no collision counter exists.
`endif

endmodule

`default_nettype wire

// File: tb/tb_l2_dat_port_ctrl.sv
`default_nettype none
// tb_l2_dat_port_ctrl : directed and randomized checks against a line-level reference model
// with a behavioural read-first BRAM attached to both ports.
module tb_l2_dat_port_ctrl;

  localparam int NC = 16;
  localparam int AW = 8;
  localparam int DW = 128;
`ifdef L2_DAT_CTRL_STATS_EN
  localparam int CW = 4;
  logic [CW-1:0] coll_cnt;
`endif

  logic clk = 1'b0;
  logic rst_ni;

  logic          d_req, d_we, i_req, i_we;
  logic [NC-1:0] d_be, i_be;
  logic [AW-1:0] d_addr, i_addr;
  logic [DW-1:0] d_wdata, i_wdata;
  logic          d_gnt, d_rvalid, i_gnt, i_rvalid;
  logic [DW-1:0] d_rdata, i_rdata;

  logic          ram_we_p1, ram_we_p2;
  logic [NC-1:0] ram_be_p1, ram_be_p2;
  logic [AW-1:0] ram_addr_p1, ram_addr_p2;
  logic [DW-1:0] ram_wdata_p1, ram_wdata_p2, ram_rdata_p1, ram_rdata_p2;

  always #5 clk = ~clk;

  l2_dat_port_ctrl #(
    .NUM_COL(NC), .COL_WIDTH(8), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
`ifdef L2_DAT_CTRL_STATS_EN
    , .CNT_WIDTH(CW)
`endif
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .i_req_i(i_req), .i_we_i(i_we), .i_be_i(i_be), .i_addr_i(i_addr), .i_wdata_i(i_wdata),
    .i_gnt_o(i_gnt), .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
    .ram_we_p1_o(ram_we_p1), .ram_be_p1_o(ram_be_p1), .ram_addr_p1_o(ram_addr_p1),
    .ram_data_p1_o(ram_wdata_p1), .ram_data_p1_i(ram_rdata_p1),
    .ram_we_p2_o(ram_we_p2), .ram_be_p2_o(ram_be_p2), .ram_addr_p2_o(ram_addr_p2),
    .ram_data_p2_o(ram_wdata_p2), .ram_data_p2_i(ram_rdata_p2)
`ifdef L2_DAT_CTRL_STATS_EN
    , .coll_cnt_o(coll_cnt)
`endif
  );

  // Behavioural true-dual-port BRAM: registered, read-first, byte-enabled.
  logic [DW-1:0] bram [2**AW] = '{default: '0};
  always @(posedge clk) begin
    ram_rdata_p1 <= bram[ram_addr_p1];
    ram_rdata_p2 <= bram[ram_addr_p2];
    for (int b = 0; b < NC; b++) begin
      if (ram_we_p1 && ram_be_p1[b]) bram[ram_addr_p1][b*8 +: 8] <= ram_wdata_p1[b*8 +: 8];
      if (ram_we_p2 && ram_be_p2[b]) bram[ram_addr_p2][b*8 +: 8] <= ram_wdata_p2[b*8 +: 8];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [2**AW] = '{default: '0};
  bit            rr_m;
  bit            exp_d_gnt, exp_i_gnt, exp_coll;
  bit            pd_v, pi_v;
  logic [DW-1:0] pd_data, pi_data;
  bit            exp_d_rvalid, exp_i_rvalid;
  logic [DW-1:0] exp_d_rdata, exp_i_rdata;
  int            coll_m;
  int            checks = 0;
  int            errors = 0;

  task automatic write_line(input logic [AW-1:0] a, input logic [NC-1:0] be, input logic [DW-1:0] wd);
    for (int b = 0; b < NC; b++) if (be[b]) ref_mem[a][b*8 +: 8] = wd[b*8 +: 8];
  endtask

`ifdef L2_DAT_CTRL_STATS_EN
  function automatic int exp_cnt();
    int lim = (1 << CW) - 1;
    return (coll_m > lim) ? lim : coll_m;
  endfunction
`endif

  // Grants for the current input set, from the arbitration rules.
  task automatic settle();
    #1;
    exp_coll = rst_ni && d_req && i_req && (d_addr == i_addr) && (d_we || i_we);
    if (!rst_ni) begin
      exp_d_gnt = 0; exp_i_gnt = 0;
    end else if (exp_coll) begin
      exp_d_gnt = (rr_m == 0); exp_i_gnt = (rr_m == 1);
    end else begin
      exp_d_gnt = d_req; exp_i_gnt = i_req;
    end
  endtask

  // Advance one rising edge and the model with it.
  task automatic clock_edge();
    @(posedge clk);
    if (!rst_ni) begin
      rr_m = 0; pd_v = 0; pi_v = 0; coll_m = 0;
      exp_d_rvalid = 0; exp_i_rvalid = 0; exp_d_rdata = '0; exp_i_rdata = '0;
    end else begin
      exp_d_rvalid = pd_v;
      exp_i_rvalid = pi_v;
      if (pd_v) exp_d_rdata = pd_data;
      if (pi_v) exp_i_rdata = pi_data;
      pd_v = exp_d_gnt && !d_we;
      pi_v = exp_i_gnt && !i_we;
      pd_data = ref_mem[d_addr];
      pi_data = ref_mem[i_addr];
      if (exp_d_gnt && d_we) write_line(d_addr, d_be, d_wdata);
      if (exp_i_gnt && i_we) write_line(i_addr, i_be, i_wdata);
      if (exp_coll) begin
        rr_m = exp_d_gnt ? 1'b1 : 1'b0;
        coll_m++;
      end
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    clock_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    i_req = 0; i_we = 0; i_be = '0; i_addr = '0; i_wdata = '0;
  endtask

  task automatic do_reset();
    rst_ni = 0; idle();
    cyc(); cyc();
    rst_ni = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_ni = 0;
    d_req = 1; d_we = 1; d_be = '1; d_addr = 8'h01; d_wdata = '1;
    i_req = 1; i_we = 1; i_be = '1; i_addr = 8'h02; i_wdata = '1;
    settle();
    checks++;
    if (d_gnt !== 1'b0 || i_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_gnt: d_gnt=%0b i_gnt=%0b required 0 0", d_gnt, i_gnt);
    end
    checks++;
    if (ram_we_p1 !== 1'b0 || ram_we_p2 !== 1'b0) begin
      errors++; $display("FAIL reset_ram_we: p1=%0b p2=%0b required 0 0", ram_we_p1, ram_we_p2);
    end
    clock_edge();
    checks++;
    if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0 || d_rdata !== '0 || i_rdata !== '0) begin
      errors++; $display("FAIL reset_resp: d_rvalid=%0b i_rvalid=%0b d_rdata=%h i_rdata=%h required all 0",
                         d_rvalid, i_rvalid, d_rdata, i_rdata);
    end
`ifdef L2_DAT_CTRL_STATS_EN
    checks++;
    if (coll_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt: coll_cnt=%0d required 0", coll_cnt);
    end
`endif
    @(negedge clk);
    rst_ni = 1; idle();
  endtask

  task automatic test_reset_mid_read();
    d_req = 1; d_we = 1; d_be = '1; d_addr = 8'h10; d_wdata = {16{8'h5A}};
    cyc();
    d_we = 0;
    settle();
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL midread_gnt: d_gnt=%0b required 1", d_gnt);
    end
    clock_edge();
    @(negedge clk);
    rst_ni = 0; idle();
    settle(); clock_edge();
    checks++;
    if (d_rvalid !== 1'b0 || d_rdata !== '0) begin
      errors++; $display("FAIL midread_reset: d_rvalid=%0b d_rdata=%h required 0 0", d_rvalid, d_rdata);
    end
    @(negedge clk);
    rst_ni = 1;
    settle(); clock_edge();
    checks++;
    if (d_rvalid !== 1'b0 || d_rdata !== '0) begin
      errors++; $display("FAIL midread_discard: d_rvalid=%0b d_rdata=%h required 0 0", d_rvalid, d_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_independent();
    d_req = 1; d_we = 1; d_be = '1; d_addr = 8'h05; d_wdata = {16{8'hA5}};
    i_req = 1; i_we = 0; i_addr = 8'h06;
    settle();
    checks++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b1) begin
      errors++; $display("FAIL indep_gnt: d_gnt=%0b i_gnt=%0b required 1 1", d_gnt, i_gnt);
    end
    clock_edge();
    @(negedge clk);
    idle();
    d_req = 1; d_we = 0; d_addr = 8'h05;
    settle();
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL indep_rd_gnt: d_gnt=%0b required 1", d_gnt);
    end
    clock_edge();
    checks++;
    if (d_rvalid !== 1'b0) begin
      errors++; $display("FAIL indep_early_rvalid: d_rvalid=%0b required 0", d_rvalid);
    end
    @(negedge clk);
    idle();
    settle(); clock_edge();
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== {16{8'hA5}}) begin
      errors++; $display("FAIL indep_rdata: d_rvalid=%0b d_rdata=%h required 1 %h", d_rvalid, d_rdata, {16{8'hA5}});
    end
    @(negedge clk);
    settle(); clock_edge();
    checks++;
    if (d_rvalid !== 1'b0 || d_rdata !== {16{8'hA5}}) begin
      errors++; $display("FAIL indep_hold: d_rvalid=%0b d_rdata=%h required 0 %h", d_rvalid, d_rdata, {16{8'hA5}});
    end
    @(negedge clk);
  endtask

  task automatic test_collision_first();
    do_reset();
    d_req = 1; d_we = 1; d_be = '1; d_addr = 8'h20; d_wdata = {16{8'h3C}};
    i_req = 1; i_we = 0; i_addr = 8'h20;
    settle();
    checks++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
      errors++; $display("FAIL coll_c0: d_gnt=%0b i_gnt=%0b required 1 0", d_gnt, i_gnt);
    end
    clock_edge();
`ifdef L2_DAT_CTRL_STATS_EN
    checks++;
    if (coll_cnt !== CW'(1)) begin
      errors++; $display("FAIL coll_cnt1: coll_cnt=%0d required 1", coll_cnt);
    end
`endif
    @(negedge clk);
    d_req = 0;
    settle();
    checks++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      errors++; $display("FAIL coll_c1: d_gnt=%0b i_gnt=%0b required 0 1", d_gnt, i_gnt);
    end
    clock_edge();
    @(negedge clk);
    idle();
    settle(); clock_edge();
    checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== {16{8'h3C}}) begin
      errors++; $display("FAIL coll_rdata: i_rvalid=%0b i_rdata=%h required 1 %h", i_rvalid, i_rdata, {16{8'h3C}});
    end
    @(negedge clk);
  endtask

  task automatic test_rr_fairness();
    d_req = 1; d_we = 1; d_be = '1; d_addr = 8'h30; d_wdata = {16{8'h11}};
    i_req = 1; i_we = 1; i_be = '1; i_addr = 8'h30; i_wdata = {16{8'h22}};
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++;
      if (i_gnt !== ((k % 2) == 0) || d_gnt !== ((k % 2) == 1) || i_gnt !== exp_i_gnt) begin
        errors++; $display("FAIL rr_k%0d: d_gnt=%0b i_gnt=%0b required %0b %0b", k, d_gnt, i_gnt,
                           (k % 2) == 1, (k % 2) == 0);
      end
      clock_edge();
`ifdef L2_DAT_CTRL_STATS_EN
      checks++;
      if (coll_cnt !== CW'(exp_cnt())) begin
        errors++; $display("FAIL rr_cnt_k%0d: coll_cnt=%0d required %0d", k, coll_cnt, exp_cnt());
      end
`endif
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_double_read();
    d_req = 1; d_we = 1; d_be = '1; d_addr = 8'h40; d_wdata = {$urandom, $urandom, $urandom, $urandom};
    cyc();
    idle();
    d_req = 1; d_addr = 8'h40; i_req = 1; i_addr = 8'h40;
    settle();
    checks++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b1) begin
      errors++; $display("FAIL dblrd_gnt: d_gnt=%0b i_gnt=%0b required 1 1", d_gnt, i_gnt);
    end
    clock_edge();
    @(negedge clk);
    idle();
    settle(); clock_edge();
    checks++;
    if (d_rvalid !== 1'b1 || i_rvalid !== 1'b1 || d_rdata !== ref_mem[8'h40] || i_rdata !== ref_mem[8'h40]) begin
      errors++; $display("FAIL dblrd_resp: d_rvalid=%0b i_rvalid=%0b d_rdata=%h i_rdata=%h required 1 1 %h",
                         d_rvalid, i_rvalid, d_rdata, i_rdata, ref_mem[8'h40]);
    end
`ifdef L2_DAT_CTRL_STATS_EN
    checks++;
    if (coll_cnt !== CW'(exp_cnt())) begin
      errors++; $display("FAIL dblrd_cnt: coll_cnt=%0d required %0d", coll_cnt, exp_cnt());
    end
`endif
    @(negedge clk);
  endtask

`ifdef L2_DAT_CTRL_STATS_EN
  task automatic test_saturation();
    do_reset();
    d_req = 1; d_we = 1; d_be = '1; d_addr = 8'h50; d_wdata = '0;
    i_req = 1; i_we = 1; i_be = '1; i_addr = 8'h50; i_wdata = '1;
    for (int k = 1; k <= 20; k++) begin
      settle(); clock_edge();
      if (k == 14 || k == 15 || k == 20) begin
        checks++;
        if (coll_cnt !== ((k < 15) ? CW'(k) : CW'(15))) begin
          errors++; $display("FAIL sat_k%0d: coll_cnt=%0d required %0d", k, coll_cnt, (k < 15) ? k : 15);
        end
      end
      @(negedge clk);
    end
    idle();
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst_ni = ($urandom_range(0, 99) != 0);
      if (!d_req || exp_d_gnt) begin
        d_req = ($urandom_range(0, 2) != 0); d_we = 1'($urandom_range(0, 1)); d_be = 16'($urandom);
        d_addr = 8'($urandom_range(0, 3)); d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end else if ($urandom_range(0, 15) == 0) d_req = 0;
      if (!i_req || exp_i_gnt) begin
        i_req = ($urandom_range(0, 2) != 0); i_we = 1'($urandom_range(0, 1)); i_be = 16'($urandom);
        i_addr = 8'($urandom_range(0, 3)); i_wdata = {$urandom, $urandom, $urandom, $urandom};
      end else if ($urandom_range(0, 15) == 0) i_req = 0;
      settle();
      checks++;
      if (d_gnt !== exp_d_gnt || i_gnt !== exp_i_gnt ||
          ram_we_p1 !== (exp_d_gnt && d_we) || ram_we_p2 !== (exp_i_gnt && i_we)) begin
        errors++; $display("FAIL rand_gnt n=%0d: gnt d/i=%0b%0b we p1/p2=%0b%0b required %0b%0b %0b%0b", n,
                           d_gnt, i_gnt, ram_we_p1, ram_we_p2, exp_d_gnt, exp_i_gnt,
                           exp_d_gnt && d_we, exp_i_gnt && i_we);
      end
      clock_edge();
      checks++;
      if (d_rvalid !== exp_d_rvalid || i_rvalid !== exp_i_rvalid ||
          d_rdata !== exp_d_rdata || i_rdata !== exp_i_rdata) begin
        errors++; $display("FAIL rand_resp n=%0d: rvalid d/i=%0b%0b d_rdata=%h i_rdata=%h required %0b%0b %h %h", n,
                           d_rvalid, i_rvalid, d_rdata, i_rdata, exp_d_rvalid, exp_i_rvalid, exp_d_rdata, exp_i_rdata);
      end
`ifdef L2_DAT_CTRL_STATS_EN
      checks++;
      if (coll_cnt !== CW'(exp_cnt())) begin
        errors++; $display("FAIL rand_cnt n=%0d: coll_cnt=%0d required %0d", n, coll_cnt, exp_cnt());
      end
`endif
      @(negedge clk);
    end
    rst_ni = 1; idle();
  endtask

  initial begin
    rst_ni = 0;
    idle();
    test_reset();
    test_reset_mid_read();
    test_independent();
    test_collision_first();
    test_rr_fairness();
    test_double_read();
`ifdef L2_DAT_CTRL_STATS_EN
    test_saturation();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
